hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised hazard controller for the 5-stage MIPS pipeline with branch resolution in ID. It replaces purely combinational hazard detection with a small state machine and stall counter. This supports configurable load latency, multi-cycle data-memory wait handshakes and masked false dependencies on `$0`. It drives the hold/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- `REG_W`, 5: register-specifier width.
- `LOAD_LAT`, 1: cycles after MEM before load data is forwardable (1..7).
- `CNT_W`, 3: stall-counter width; must hold LOAD_LAT+1.

- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `id_rs`, `id_rt` in REG_W: source registers of the instruction in ID.
- `id_use_rs`, `id_use_rt` in 1: ID instruction actually reads rs / rt.
- `id_branch` in 1: beq or bne in ID.
- `id_jump` in 1: j/jal in ID.
- `br_taken` in 1: ID comparator outcome already qualified by beq/bne.
- `ex_memread`, `ex_regwrite` in 1; `ex_rd` in REG_W: destination of EX instruction.
- `mem_memread` in 1; `mem_rd` in REG_W: destination of MEM instruction.
- `dmem_req` in 1: MEM stage accesses data memory this cycle.
- `dmem_ready` in 1: data memory completes access this cycle.
- `pc_hold`, `if_id_hold`, `id_ex_flush`, `if_flush`, `ex_mem_hold`, `mem_wb_bubble` out 1: pipeline controls.
- `busy` out 1: state is not IDLE.

## Operation
- Match `m(x)` = (x != 0) & ((id_use_rs & x==id_rs) | (id_use_rt & x==id_rt)).
- Required stall length N, evaluated in IDLE, first matching rule wins:
  1. `id_branch & ex_memread & m(ex_rd)` gives N = LOAD_LAT+1.
  2. `ex_memread & m(ex_rd)` gives N = LOAD_LAT.
  3. `id_branch & mem_memread & m(mem_rd)` gives N = LOAD_LAT.
  4. `id_branch & ex_regwrite & m(ex_rd)` gives N = 1.
  5. Otherwise N = 0.
- States are IDLE, STALL and MEM_WAIT, with `cnt` and `ret` (return state) registers.
- IDLE:
  - If N>0, this cycle is stall cycle 1.
  - If N>1, go to STALL with cnt = N-1.
- STALL:
  - Stall outputs are asserted and hazard detection is masked.
  - cnt decrements each cycle; when cnt==1, go to IDLE.
- Stall outputs (IDLE with N>0, or STALL): `pc_hold`=`if_id_hold`=`id_ex_flush`=1; `ex_mem_hold`=`mem_wb_bubble`=0.
- MEM_WAIT entry has highest priority: `dmem_req & ~dmem_ready` in any state saves ret = current state (cnt unchanged) and goes to MEM_WAIT. That cycle already drives freeze outputs.
- MEM_WAIT freeze outputs: `pc_hold`=`if_id_hold`=`ex_mem_hold`=`mem_wb_bubble`=1, `id_ex_flush`=0, `if_flush`=0. cnt is frozen.
- MEM_WAIT exit: on `dmem_ready`, freeze outputs are still driven that cycle, then return to ret. A pending stall resumes with its remaining count.
- `if_flush` = (`id_jump` | (`id_branch` & `br_taken`)) & ~`pc_hold`. A branch never flushes while its operands are stalled.
- Simultaneous load-use and memory wait: memory wait wins. Detection is re-evaluated in IDLE after the wait ends.

## Timing
- Outputs are combinational from state, cnt and inputs. There is no added latency: detection and its controls occur in the same cycle.
- Reset: while `rst_n`=0, all outputs are 0. On the next edge, state=IDLE, cnt=0, ret=IDLE.
- Reset mid-stall or mid-wait abandons the sequence; the next cycle is IDLE.
- Stall length is exact: N consecutive cycles of `pc_hold`, plus any MEM_WAIT cycles inserted in between.
- cnt never underflows. Counter wrap is impossible by the CNT_W constraint; an elaboration check fails if 2**CNT_W ≤ LOAD_LAT+1.

## Configuration
- `HAZARD_STATS_EN` defined: adds outputs `stall_cycles` and `flush_count`, 32-bit each, reset to 0, saturating at all-ones.
  - `stall_cycles` increments each cycle `pc_hold`=1.
  - `flush_count` increments each cycle `if_flush`=1.
- Undefined: those ports and counters do not exist. Behaviour is otherwise identical.

## Test plan
- `lw $2` in EX (ex_rd=2, ex_memread=1), `add` in ID reading rs=2, LOAD_LAT=1 -> `pc_hold`/`id_ex_flush` high exactly 1 cycle. With LOAD_LAT=3 -> high exactly 3 cycles.
- `lw $4` in EX, `beq $4,$5` in ID, LOAD_LAT=1 -> 2 stall cycles, `if_flush`=0 throughout, then `if_flush`=1 on the release cycle if br_taken=1.
- ex_rd=0 with ex_memread=1, id_rs=0; and ex_rd=7 with id_use_rt=0, id_rt=7 -> no stall.
- During a 3-cycle load stall, assert `dmem_req`=1, `dmem_ready`=0 for 4 cycles at stall cycle 2 -> 4 freeze cycles then 2 cycles of remaining stall, total `pc_hold` = 3+4+1 (the entry/ready-cycle accounting) verified cycle by cycle.
- Pull `rst_n` low during STALL -> outputs 0 immediately, `busy`=0 next cycle, no residual stall.
- With `HAZARD_STATS_EN`: one jump plus one 2-cycle stall -> `flush_count`=1, `stall_cycles`=2.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard sources in, pipeline hold/flush controls out.
// master = pipeline datapath, slave = hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_branch;
    logic             id_jump;
    logic             br_taken;
    logic             ex_memread;
    logic             ex_regwrite;
    logic [REG_W-1:0] ex_rd;
    logic             mem_memread;
    logic [REG_W-1:0] mem_rd;
    logic             dmem_req;
    logic             dmem_ready;

    logic             pc_hold;
    logic             if_id_hold;
    logic             id_ex_flush;
    logic             if_flush;
    logic             ex_mem_hold;
    logic             mem_wb_bubble;
    logic             busy;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_jump, br_taken,
               ex_memread, ex_regwrite, ex_rd, mem_memread, mem_rd, dmem_req, dmem_ready,
        input  pc_hold, if_id_hold, id_ex_flush, if_flush, ex_mem_hold, mem_wb_bubble, busy
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_jump, br_taken,
               ex_memread, ex_regwrite, ex_rd, mem_memread, mem_rd, dmem_req, dmem_ready,
        output pc_hold, if_id_hold, id_ex_flush, if_flush, ex_mem_hold, mem_wb_bubble, busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline (branches resolved in ID): counted load/branch
// stalls plus data-memory wait freeze. Define HAZARD_STATS_EN to add stall/flush statistics ports.
module hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]  stall_cycles,
    output logic [31:0]  flush_count
`endif
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_STALL    = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [REG_W-1:0] REG_ZERO = '0;
    localparam logic [CNT_W-1:0] LAT_N    = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] LAT_N_P1 = CNT_W'(LOAD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if ((2 ** CNT_W) <= LOAD_LAT + 1) begin : g_cnt_w_too_narrow
        $error("hazard_ctrl: CNT_W=%0d cannot hold LOAD_LAT+1=%0d", CNT_W, LOAD_LAT + 1);
    end
    if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_load_lat_range
        $error("hazard_ctrl: LOAD_LAT=%0d outside 1..7", LOAD_LAT);
    end

    state_t           r_state, r_ret, w_state_nxt, w_ret_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_need;
    logic             w_hit_ex, w_hit_mem, w_wait_entry;
    logic             w_freeze, w_stall, w_hold, w_redirect;

    // $0 never carries a real dependency, so a zero destination never matches.
    assign w_hit_ex  = (hz.ex_rd != REG_ZERO) &
                       ((hz.id_use_rs & (hz.ex_rd == hz.id_rs)) | (hz.id_use_rt & (hz.ex_rd == hz.id_rt)));
    assign w_hit_mem = (hz.mem_rd != REG_ZERO) &
                       ((hz.id_use_rs & (hz.mem_rd == hz.id_rs)) | (hz.id_use_rt & (hz.mem_rd == hz.id_rt)));
    assign w_wait_entry = hz.dmem_req & ~hz.dmem_ready;

    // NOTE: every always_comb variable gets a default first, so no path can infer a latch.
    always_comb begin
        w_need = '0;
        if (hz.id_branch & hz.ex_memread & w_hit_ex)        w_need = LAT_N_P1;
        else if (hz.ex_memread & w_hit_ex)                  w_need = LAT_N;
        else if (hz.id_branch & hz.mem_memread & w_hit_mem) w_need = LAT_N;
        else if (hz.id_branch & hz.ex_regwrite & w_hit_ex)  w_need = CNT_ONE;
    end

    // NOTE: state uses non-blocking assignments; the reset is synchronous and sampled on clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ret   <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ret   <= w_ret_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_wait_entry) begin
                    w_state_nxt = S_MEM_WAIT;
                    w_ret_nxt   = S_IDLE;
                end else if (w_need > CNT_ONE) begin
                    w_state_nxt = S_STALL;
                    w_cnt_nxt   = w_need - CNT_ONE;
                end
            end
            S_STALL: begin
                if (w_wait_entry) begin
                    w_state_nxt = S_MEM_WAIT;
                    w_ret_nxt   = S_STALL;
                end else begin
                    w_cnt_nxt = (r_cnt > CNT_ONE) ? r_cnt - CNT_ONE : '0;
                    if (r_cnt <= CNT_ONE) w_state_nxt = S_IDLE;
                end
            end
            S_MEM_WAIT: begin
                if (hz.dmem_ready) w_state_nxt = r_ret;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A memory wait overrides any stall; its entry cycle already freezes.
    always_comb begin
        w_freeze = 1'b0;
        w_stall  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_freeze = w_wait_entry;
                w_stall  = ~w_wait_entry & (w_need != '0);
            end
            S_STALL: begin
                w_freeze = w_wait_entry;
                w_stall  = ~w_wait_entry;
            end
            S_MEM_WAIT: w_freeze = 1'b1;
            default: ;
        endcase
    end

    assign w_hold     = w_freeze | w_stall;
    assign w_redirect = hz.id_jump | (hz.id_branch & hz.br_taken);

    assign hz.pc_hold       = rst_n & w_hold;
    assign hz.if_id_hold    = rst_n & w_hold;
    assign hz.id_ex_flush   = rst_n & w_stall;
    assign hz.ex_mem_hold   = rst_n & w_freeze;
    assign hz.mem_wb_bubble = rst_n & w_freeze;
    assign hz.if_flush      = rst_n & w_redirect & ~w_hold;
    assign hz.busy          = rst_n & (r_state != S_IDLE);

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cycles, r_flush_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_hold && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_redirect && !w_hold && (r_flush_count != '1))
                r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign stall_cycles = rst_n ? r_stall_cycles : '0;
    assign flush_count  = rst_n ? r_flush_count  : '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus;
// directed vector tables, multi-cycle sequences, then random traffic against a behavioural model.
module tb_hazard_ctrl;
    localparam int REG_W = 5;

    // Output vector order: {pc_hold, if_id_hold, id_ex_flush, if_flush, ex_mem_hold, mem_wb_bubble, busy}
    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_ST0  = 7'b1110000;
    localparam logic [6:0] O_ST1  = 7'b1110001;
    localparam logic [6:0] O_FZ0  = 7'b1100110;
    localparam logic [6:0] O_FZ1  = 7'b1100111;
    localparam logic [6:0] O_FL   = 7'b0001000;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       branch;
        logic       jump;
        logic       taken;
        logic       ex_mr;
        logic       ex_rw;
        logic [4:0] ex_rd;
        logic       mem_mr;
        logic [4:0] mem_rd;
        logic       req;
        logic       rdy;
    } in_t;

    typedef struct {
        string      name;
        bit         rst_first;
        bit         rst_in;
        in_t        in;
        logic [6:0] exp_l1;
        logic [6:0] exp_l3;
    } vec_t;

    localparam in_t I_NONE      = '0;
    localparam in_t I_LU_RS     = '{rs: 5'd2, use_rs: 1'b1, ex_mr: 1'b1, ex_rd: 5'd2, default: 0};
    localparam in_t I_LU_RT     = '{rt: 5'd9, use_rt: 1'b1, ex_mr: 1'b1, ex_rd: 5'd9, default: 0};
    localparam in_t I_ZERO      = '{use_rs: 1'b1, ex_mr: 1'b1, default: 0};
    localparam in_t I_RT_UNUSED = '{rs: 5'd3, use_rs: 1'b1, rt: 5'd7, ex_mr: 1'b1, ex_rd: 5'd7, default: 0};
    localparam in_t I_ALU       = '{rt: 5'd5, use_rt: 1'b1, ex_rw: 1'b1, ex_rd: 5'd5, default: 0};
    localparam in_t I_ALU0      = '{use_rs: 1'b1, ex_rw: 1'b1, default: 0};
    localparam in_t I_MEM_LD    = '{rs: 5'd6, use_rs: 1'b1, mem_mr: 1'b1, mem_rd: 5'd6, default: 0};
    localparam in_t I_BR        = '{branch: 1'b1, default: 0};
    localparam in_t I_BRT       = '{branch: 1'b1, taken: 1'b1, default: 0};
    localparam in_t I_JUMP      = '{jump: 1'b1, default: 0};
    localparam in_t I_WAIT      = '{req: 1'b1, default: 0};
    localparam in_t I_READY     = '{req: 1'b1, rdy: 1'b1, default: 0};
    localparam in_t I_BR_LD     = '{branch: 1'b1, taken: 1'b1, rs: 5'd4, use_rs: 1'b1, rt: 5'd5,
                                    use_rt: 1'b1, ex_mr: 1'b1, ex_rd: 5'd4, default: 0};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    in_t  drv   = '0;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[$];
    int   model_left[2];
    bit   model_wait[2];

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_W(REG_W)) bus_l1 ();
    hazard_ctrl_if #(.REG_W(REG_W)) bus_l3 ();

    assign bus_l1.id_rs       = drv.rs;     assign bus_l3.id_rs       = drv.rs;
    assign bus_l1.id_rt       = drv.rt;     assign bus_l3.id_rt       = drv.rt;
    assign bus_l1.id_use_rs   = drv.use_rs; assign bus_l3.id_use_rs   = drv.use_rs;
    assign bus_l1.id_use_rt   = drv.use_rt; assign bus_l3.id_use_rt   = drv.use_rt;
    assign bus_l1.id_branch   = drv.branch; assign bus_l3.id_branch   = drv.branch;
    assign bus_l1.id_jump     = drv.jump;   assign bus_l3.id_jump     = drv.jump;
    assign bus_l1.br_taken    = drv.taken;  assign bus_l3.br_taken    = drv.taken;
    assign bus_l1.ex_memread  = drv.ex_mr;  assign bus_l3.ex_memread  = drv.ex_mr;
    assign bus_l1.ex_regwrite = drv.ex_rw;  assign bus_l3.ex_regwrite = drv.ex_rw;
    assign bus_l1.ex_rd       = drv.ex_rd;  assign bus_l3.ex_rd       = drv.ex_rd;
    assign bus_l1.mem_memread = drv.mem_mr; assign bus_l3.mem_memread = drv.mem_mr;
    assign bus_l1.mem_rd      = drv.mem_rd; assign bus_l3.mem_rd      = drv.mem_rd;
    assign bus_l1.dmem_req    = drv.req;    assign bus_l3.dmem_req    = drv.req;
    assign bus_l1.dmem_ready  = drv.rdy;    assign bus_l3.dmem_ready  = drv.rdy;

    logic [6:0] out_l1, out_l3;
    assign out_l1 = {bus_l1.pc_hold, bus_l1.if_id_hold, bus_l1.id_ex_flush, bus_l1.if_flush,
                     bus_l1.ex_mem_hold, bus_l1.mem_wb_bubble, bus_l1.busy};
    assign out_l3 = {bus_l3.pc_hold, bus_l3.if_id_hold, bus_l3.id_ex_flush, bus_l3.if_flush,
                     bus_l3.ex_mem_hold, bus_l3.mem_wb_bubble, bus_l3.busy};

`ifdef HAZARD_STATS_EN
    logic [31:0] sc_l1, fc_l1, sc_l3, fc_l3;
`endif

    hazard_ctrl #(.REG_W(REG_W), .LOAD_LAT(1), .CNT_W(3)) u_dut_l1 (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus_l1)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles (sc_l1),
        .flush_count  (fc_l1)
`endif
    );

    hazard_ctrl #(.REG_W(REG_W), .LOAD_LAT(3), .CNT_W(3)) u_dut_l3 (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus_l3)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles (sc_l3),
        .flush_count  (fc_l3)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input bit rst_first, input bit rst_in, input in_t in,
                       input logic [6:0] e1, input logic [6:0] e3);
        vec_t v;
        v.name = name; v.rst_first = rst_first; v.rst_in = rst_in;
        v.in = in; v.exp_l1 = e1; v.exp_l3 = e3;
        tbl.push_back(v);
    endtask

    // Holds reset one cycle with hazards present; all outputs must read 0 meanwhile.
    task automatic do_reset();
        rst_n = 1'b0;
        drv   = I_LU_RS | I_JUMP | I_WAIT;
        @(negedge clk);
        check("rst_out_l1", {25'd0, out_l1}, {25'd0, O_NONE});
        check("rst_out_l3", {25'd0, out_l3}, {25'd0, O_NONE});
        @(posedge clk); #1;
        rst_n = 1'b1;
        drv   = I_NONE;
    endtask

    task automatic apply(input vec_t v);
        if (v.rst_first) do_reset();
        rst_n = v.rst_in;
        drv   = v.in;
        @(negedge clk);
        check({v.name, "_l1"}, {25'd0, out_l1}, {25'd0, v.exp_l1});
        check({v.name, "_l3"}, {25'd0, out_l3}, {25'd0, v.exp_l3});
        @(posedge clk); #1;
    endtask

    function automatic bit hit(input in_t x, input logic [4:0] r);
        return (r != 5'd0) && ((x.use_rs && r == x.rs) || (x.use_rt && r == x.rt));
    endfunction

    function automatic int need(input int lat, input in_t x);
        if (x.branch && x.ex_mr && hit(x, x.ex_rd))   return lat + 1;
        if (x.ex_mr && hit(x, x.ex_rd))               return lat;
        if (x.branch && x.mem_mr && hit(x, x.mem_rd)) return lat;
        if (x.branch && x.ex_rw && hit(x, x.ex_rd))   return 1;
        return 0;
    endfunction

    // Model: remaining stall cycles and an outstanding-wait flag; waits suspend the stall count.
    task automatic model_step(input int k, input int lat, input in_t x, input bit rst,
                              output logic [6:0] e);
        bit busy, frz, stl, hold, flush;
        int n;
        busy = model_wait[k] || (model_left[k] > 0);
        frz = 1'b0; stl = 1'b0;
        if (!rst) begin
            e = O_NONE;
            model_left[k] = 0;
            model_wait[k] = 1'b0;
            return;
        end
        if (model_wait[k]) begin
            frz = 1'b1;
            if (x.rdy) model_wait[k] = 1'b0;
        end else if (x.req && !x.rdy) begin
            frz = 1'b1;
            model_wait[k] = 1'b1;
        end else if (model_left[k] > 0) begin
            stl = 1'b1;
            model_left[k]--;
        end else begin
            n = need(lat, x);
            if (n > 0) begin
                stl = 1'b1;
                model_left[k] = n - 1;
            end
        end
        hold  = frz | stl;
        flush = (x.jump | (x.branch & x.taken)) & ~hold;
        e = {hold, hold, stl, flush, frz, frz, busy};
    endtask

    initial begin
        // Single-cycle decisions, each from a fresh reset.
        add("idle",        1, 1, I_NONE,             O_NONE, O_NONE);
        add("lu_rs",       1, 1, I_LU_RS,            O_ST0,  O_ST0);
        add("lu_rt",       1, 1, I_LU_RT,            O_ST0,  O_ST0);
        add("zero_reg",    1, 1, I_ZERO,             O_NONE, O_NONE);
        add("rt_unused",   1, 1, I_RT_UNUSED,        O_NONE, O_NONE);
        add("br_alu",      1, 1, I_ALU | I_BR,       O_ST0,  O_ST0);
        add("alu_nobr",    1, 1, I_ALU,              O_NONE, O_NONE);
        add("br_alu_zero", 1, 1, I_ALU0 | I_BR,      O_NONE, O_NONE);
        add("br_mem_ld",   1, 1, I_MEM_LD | I_BRT,   O_ST0,  O_ST0);
        add("mem_ld_nobr", 1, 1, I_MEM_LD,           O_NONE, O_NONE);
        add("jump",        1, 1, I_JUMP,             O_FL,   O_FL);
        add("br_taken",    1, 1, I_BRT,              O_FL,   O_FL);
        add("br_nt",       1, 1, I_BR,               O_NONE, O_NONE);
        add("br_stalled",  1, 1, I_BR_LD,            O_ST0,  O_ST0);
        add("wait_idle",   1, 1, I_LU_RS | I_WAIT,   O_FZ0,  O_FZ0);
        add("req_ready",   1, 1, I_READY,            O_NONE, O_NONE);
        add("jump_wait",   1, 1, I_JUMP | I_WAIT,    O_FZ0,  O_FZ0);
        // Load-use stall length: 1 cycle at LOAD_LAT=1, 3 cycles at LOAD_LAT=3.
        add("lu_c1", 1, 1, I_LU_RS, O_ST0,  O_ST0);
        add("lu_c2", 0, 1, I_NONE,  O_NONE, O_ST1);
        add("lu_c3", 0, 1, I_NONE,  O_NONE, O_ST1);
        add("lu_c4", 0, 1, I_NONE,  O_NONE, O_NONE);
        // Branch on a load result: no flush while stalled, flush on release.
        add("br_c1", 1, 1, I_BR_LD, O_ST0, O_ST0);
        add("br_c2", 0, 1, I_BR_LD, O_ST1, O_ST1);
        add("br_c3", 0, 1, I_BRT,   O_FL,  O_ST1);
        add("br_c4", 0, 1, I_BRT,   O_FL,  O_ST1);
        add("br_c5", 0, 1, I_BRT,   O_FL,  O_FL);
        // Memory wait arriving at stall cycle 2, four not-ready cycles then ready.
        add("mw_c1", 1, 1, I_LU_RS, O_ST0,  O_ST0);
        add("mw_c2", 0, 1, I_WAIT,  O_FZ0,  O_FZ1);
        add("mw_c3", 0, 1, I_WAIT,  O_FZ1,  O_FZ1);
        add("mw_c4", 0, 1, I_WAIT,  O_FZ1,  O_FZ1);
        add("mw_c5", 0, 1, I_WAIT,  O_FZ1,  O_FZ1);
        add("mw_c6", 0, 1, I_READY, O_FZ1,  O_FZ1);
        add("mw_c7", 0, 1, I_NONE,  O_NONE, O_ST1);
        add("mw_c8", 0, 1, I_NONE,  O_NONE, O_ST1);
        add("mw_c9", 0, 1, I_NONE,  O_NONE, O_NONE);
        // Hazard re-evaluated after a wait entered from IDLE.
        add("re_c1", 1, 1, I_LU_RS | I_WAIT,  O_FZ0, O_FZ0);
        add("re_c2", 0, 1, I_LU_RS | I_READY, O_FZ1, O_FZ1);
        add("re_c3", 0, 1, I_LU_RS,           O_ST0, O_ST0);
        // Reset in the middle of a stall and of a wait.
        add("rs_c1", 1, 1, I_LU_RS, O_ST0,  O_ST0);
        add("rs_c2", 0, 1, I_NONE,  O_NONE, O_ST1);
        add("rs_c3", 0, 0, I_LU_RS, O_NONE, O_NONE);
        add("rs_c4", 0, 1, I_NONE,  O_NONE, O_NONE);
        add("rs_c5", 0, 1, I_LU_RS, O_ST0,  O_ST0);
        add("rw_c1", 1, 1, I_WAIT,  O_FZ0,  O_FZ0);
        add("rw_c2", 0, 1, I_WAIT,  O_FZ1,  O_FZ1);
        add("rw_c3", 0, 0, I_WAIT,  O_NONE, O_NONE);
        add("rw_c4", 0, 1, I_NONE,  O_NONE, O_NONE);
        // One jump then a branch-on-load stall (2 cycles at LOAD_LAT=1, 4 at LOAD_LAT=3).
        add("st_c1", 1, 1, I_JUMP,          O_FL,   O_FL);
        add("st_c2", 0, 1, I_LU_RS | I_BR,  O_ST0,  O_ST0);
        add("st_c3", 0, 1, I_NONE,          O_ST1,  O_ST1);
        add("st_c4", 0, 1, I_NONE,          O_NONE, O_ST1);
        add("st_c5", 0, 1, I_NONE,          O_NONE, O_ST1);
        add("st_c6", 0, 1, I_NONE,          O_NONE, O_NONE);

        @(posedge clk); #1;
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

`ifdef HAZARD_STATS_EN
        check("stall_cycles_l1", sc_l1, 32'd2);
        check("flush_count_l1",  fc_l1, 32'd1);
        check("stall_cycles_l3", sc_l3, 32'd4);
        check("flush_count_l3",  fc_l3, 32'd1);
`endif

        // Random traffic against the behavioural model.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            model_left[k] = 0;
            model_wait[k] = 1'b0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_t        x;
            bit         r;
            logic [6:0] e1, e3;
            x.rs     = 5'($urandom_range(0, 3));
            x.rt     = 5'($urandom_range(0, 3));
            x.use_rs = 1'($urandom_range(0, 1));
            x.use_rt = 1'($urandom_range(0, 1));
            x.branch = ($urandom_range(0, 2) == 0);
            x.jump   = ($urandom_range(0, 5) == 0);
            x.taken  = 1'($urandom_range(0, 1));
            x.ex_mr  = ($urandom_range(0, 2) == 0);
            x.ex_rw  = 1'($urandom_range(0, 1));
            x.ex_rd  = 5'($urandom_range(0, 3));
            x.mem_mr = ($urandom_range(0, 2) == 0);
            x.mem_rd = 5'($urandom_range(0, 3));
            x.req    = ($urandom_range(0, 5) == 0);
            x.rdy    = 1'($urandom_range(0, 1));
            r        = ($urandom_range(0, 49) != 0);
            rst_n = r;
            drv   = x;
            @(negedge clk);
            model_step(0, 1, x, r, e1);
            model_step(1, 3, x, r, e3);
            check("rand_l1", {25'd0, out_l1}, {25'd0, e1});
            check("rand_l3", {25'd0, out_l3}, {25'd0, e3});
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
